// File: rtl/data_ram_bank_arbiter_if.sv
// Bus bundle between the LSU requester ports, the bank arbiter and the SRAM banks.
// Signal names keep the arbiter-relative direction suffix: _i is driven by the requester/bank
// side (master modport), _o is driven by the arbiter (slave modport).
//   req_*   : per-requester request channel (valid/ready handshake)
//   rsp_*   : per-requester response channel (no backpressure)
//   bank_*  : per-bank single-port SRAM macro interface (1-cycle read latency)
`timescale 1ns/1ps
interface data_ram_bank_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BANK_AW   = 13
);
  logic [NUM_REQ-1:0]              req_valid_i;
  logic [NUM_REQ-1:0]              req_ready_o;
  logic [NUM_REQ*ADDR_W-1:0]       req_addr_i;
  logic [NUM_REQ-1:0]              req_we_i;
  logic [NUM_REQ*DATA_W/8-1:0]     req_be_i;
  logic [NUM_REQ*DATA_W-1:0]       req_wdata_i;
  logic [NUM_REQ-1:0]              rsp_valid_o;
  logic [NUM_REQ*DATA_W-1:0]       rsp_rdata_o;
  logic [NUM_REQ-1:0]              rsp_err_o;
  logic [NUM_BANKS-1:0]            bank_req_o;
  logic [NUM_BANKS-1:0]            bank_we_o;
  logic [NUM_BANKS*BANK_AW-1:0]    bank_addr_o;
  logic [NUM_BANKS*DATA_W/8-1:0]   bank_be_o;
  logic [NUM_BANKS*DATA_W-1:0]     bank_wdata_o;
  logic [NUM_BANKS*DATA_W-1:0]     bank_rdata_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i, bank_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output bank_req_o, bank_we_o, bank_addr_o, bank_be_o, bank_wdata_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i, bank_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  bank_req_o, bank_we_o, bank_addr_o, bank_be_o, bank_wdata_o
  );
endinterface

// File: rtl/data_ram_bank_arbiter.sv
// Shares the data-RAM banks between NUM_REQ requesters. Each address is decoded to a bank and
// word; every bank runs its own round-robin arbiter and drives a single-port SRAM macro with
// 1-cycle read latency. Responses return in order, one cycle after acceptance.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   bus (slave)     : request/response channels and bank SRAM signals (see interface file)
//   perf_conflict_o : per-bank saturating conflict counters (only with DATA_RAM_ARB_PERF_CNT_EN)
// Optional feature macro: DATA_RAM_ARB_PERF_CNT_EN.
`timescale 1ns/1ps
module data_ram_bank_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] BANK_SIZE = 32'h8000,
  parameter logic [31:0] DATA_BASE = 32'h8000
) (
  input logic                    clk,
  input logic                    reset,
  data_ram_bank_arbiter_if.slave bus
`ifdef DATA_RAM_ARB_PERF_CNT_EN
  ,
  output logic [NUM_BANKS*32-1:0] perf_conflict_o
`endif
);

  localparam int unsigned BeW   = DATA_W / 8;
  localparam int unsigned BankW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned ReqW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned OffW  = $clog2(BANK_SIZE);
  localparam int unsigned WordW = OffW - 2;
  localparam int unsigned LoW   = OffW + BankW;

  localparam logic [ADDR_W-1:0] DataBase = ADDR_W'(DATA_BASE);
  localparam logic [ADDR_W-1:0] DataEnd  = ADDR_W'(DATA_BASE + NUM_BANKS * BANK_SIZE);

  // ---------------------------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------------------------
  logic [NUM_REQ-1:0] dec_err;
  logic [LoW-1:0]     dec_off  [NUM_REQ];
  logic [BankW-1:0]   dec_bank [NUM_REQ];
  logic [WordW-1:0]   dec_word [NUM_REQ];

  always_comb begin
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      // Only the low bits of the offset matter once the range check has passed.
      dec_off[r]  = bus.req_addr_i[r*ADDR_W +: LoW] - DataBase[LoW-1:0];
      dec_bank[r] = dec_off[r][OffW +: BankW];
      dec_word[r] = dec_off[r][OffW-1:2];
      // DATA_BASE is word aligned, so offset alignment equals address alignment.
      dec_err[r]  = (bus.req_addr_i[r*ADDR_W +: ADDR_W] < DataBase) ||
                    (bus.req_addr_i[r*ADDR_W +: ADDR_W] >= DataEnd) ||
                    (dec_off[r][1:0] != 2'b00);
    end
  end

  // Valid, decodable requests per bank.
  logic [NUM_REQ-1:0] cand [NUM_BANKS];

  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      cand[b] = '0;
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        cand[b][r] = bus.req_valid_i[r] && !dec_err[r] && (dec_bank[r] == BankW'(b));
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Per-bank round-robin arbitration
  // ---------------------------------------------------------------------------------------------
  logic [ReqW-1:0]      rr_q    [NUM_BANKS];
  logic [NUM_BANKS-1:0] gnt_v;
  logic [ReqW-1:0]      gnt_idx [NUM_BANKS];
  int unsigned          k;

  always_comb begin
    k = 0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      gnt_v[b]   = 1'b0;
      gnt_idx[b] = '0;
      if (!reset) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          k = (32'(rr_q[b]) + i) % NUM_REQ;
          if (!gnt_v[b] && cand[b][ReqW'(k)]) begin
            gnt_v[b]   = 1'b1;
            gnt_idx[b] = ReqW'(k);
          end
        end
      end
    end
  end

  // A requester targets exactly one bank, so it can win at most one grant per cycle.
  // Error requests are accepted immediately and never reach a bank.
  always_comb begin
    bus.req_ready_o = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      bus.req_ready_o[r] = !reset && bus.req_valid_i[r] && dec_err[r];
    end
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (gnt_v[b]) begin
        bus.req_ready_o[gnt_idx[b]] = 1'b1;
      end
    end
  end

  // Bank outputs follow the granted request; all zero while the bank is idle.
  always_comb begin
    bus.bank_req_o   = '0;
    bus.bank_we_o    = '0;
    bus.bank_addr_o  = '0;
    bus.bank_be_o    = '0;
    bus.bank_wdata_o = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (gnt_v[b]) begin
        bus.bank_req_o[b]                  = 1'b1;
        bus.bank_we_o[b]                   = bus.req_we_i[gnt_idx[b]];
        bus.bank_addr_o[b*WordW +: WordW]  = dec_word[gnt_idx[b]];
        bus.bank_be_o[b*BeW +: BeW]        = bus.req_be_i[gnt_idx[b]*BeW +: BeW];
        bus.bank_wdata_o[b*DATA_W +: DATA_W] = bus.req_wdata_i[gnt_idx[b]*DATA_W +: DATA_W];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Response pipeline and pointer state
  // ---------------------------------------------------------------------------------------------
  logic [NUM_REQ-1:0] rsp_v_q;
  logic [NUM_REQ-1:0] rsp_err_q;
  logic [NUM_REQ-1:0] rsp_we_q;
  logic [BankW-1:0]   rsp_bank_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_v_q   <= '0;
      rsp_err_q <= '0;
      rsp_we_q  <= '0;
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        rsp_bank_q[r] <= '0;
      end
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        rr_q[b] <= '0;
      end
    end else begin
      rsp_v_q   <= bus.req_ready_o;
      rsp_err_q <= bus.req_ready_o & dec_err;
      rsp_we_q  <= bus.req_ready_o & bus.req_we_i;
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        rsp_bank_q[r] <= dec_bank[r];
      end
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (gnt_v[b]) begin
          rr_q[b] <= ReqW'((32'(gnt_idx[b]) + 1) % NUM_REQ);
        end
      end
    end
  end

  // Masking with reset drops a response that would otherwise show during the reset cycle.
  always_comb begin
    bus.rsp_valid_o = rsp_v_q & ~{NUM_REQ{reset}};
    bus.rsp_err_o   = rsp_err_q & ~{NUM_REQ{reset}};
    bus.rsp_rdata_o = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (bus.rsp_valid_o[r] && !rsp_err_q[r] && !rsp_we_q[r]) begin
        bus.rsp_rdata_o[r*DATA_W +: DATA_W] = bus.bank_rdata_i[rsp_bank_q[r]*DATA_W +: DATA_W];
      end
    end
  end

`ifdef DATA_RAM_ARB_PERF_CNT_EN
  // ---------------------------------------------------------------------------------------------
  // Conflict counters: cycles with two or more contenders on a bank, saturating
  // ---------------------------------------------------------------------------------------------
  logic [31:0] conflict_q [NUM_BANKS];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (reset) begin
        conflict_q[b] <= '0;
      end else if (($countones(cand[b]) >= 2) && (conflict_q[b] != 32'hFFFF_FFFF)) begin
        conflict_q[b] <= conflict_q[b] + 32'd1;
      end
    end
  end

  always_comb begin
    perf_conflict_o = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      perf_conflict_o[b*32 +: 32] = conflict_q[b];
    end
  end
`endif

endmodule

// File: tb/tb_data_ram_bank_arbiter.sv
// Directed self-checking bench for data_ram_bank_arbiter. A behavioural write-first SRAM per
// bank supplies read data; its contents start as 0xA0bb_wwww (b = bank, w = word).
`timescale 1ns/1ps
module tb_data_ram_bank_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned NB = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  data_ram_bank_arbiter_if #(.NUM_REQ(NR), .NUM_BANKS(NB), .ADDR_W(32), .DATA_W(32),
                             .BANK_AW(13)) bif ();

`ifdef DATA_RAM_ARB_PERF_CNT_EN
  logic [NB*32-1:0] perf;
`endif

  data_ram_bank_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
`ifdef DATA_RAM_ARB_PERF_CNT_EN
    ,
    .perf_conflict_o (perf)
`endif
  );

  // Behavioural SRAM banks, write-first.
  logic [31:0] mem  [NB][8192];
  logic [31:0] rd_q [NB];

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bif.bank_req_o[b]) begin
        automatic logic [12:0] a  = bif.bank_addr_o[b*13 +: 13];
        automatic logic [31:0] nv = mem[b][a];
        if (bif.bank_we_o[b]) begin
          for (int j = 0; j < 4; j++) begin
            if (bif.bank_be_o[b*4 + j]) nv[8*j +: 8] = bif.bank_wdata_o[b*32 + 8*j +: 8];
          end
          mem[b][a] <= nv;
        end
        rd_q[b] <= nv;
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NB; b++) bif.bank_rdata_i[b*32 +: 32] = rd_q[b];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [31:0] a, input logic we,
                         input logic [3:0] be, input logic [31:0] wd);
    bif.req_valid_i[r]          = v;
    bif.req_addr_i[r*32 +: 32]  = a;
    bif.req_we_i[r]             = we;
    bif.req_be_i[r*4 +: 4]      = be;
    bif.req_wdata_i[r*32 +: 32] = wd;
  endtask

  task automatic clear_all();
    bif.req_valid_i = '0;
    bif.req_we_i    = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] err_addr [3];
    logic [3:0]  onehot;
    err_addr[0] = 32'h0000_4000;
    err_addr[1] = 32'h0002_8000;
    err_addr[2] = 32'h0000_8002;

    for (int b = 0; b < NB; b++) begin
      rd_q[b] = '0;
      for (int w = 0; w < 8192; w++) mem[b][w] = 32'hA000_0000 | (b << 16) | w;
    end
    bif.req_valid_i = '0;
    bif.req_addr_i  = '0;
    bif.req_we_i    = '0;
    bif.req_be_i    = '0;
    bif.req_wdata_i = '0;

    // Reset: outputs idle even with a pending request.
    reset = 1'b1;
    set_req(0, 1'b1, 32'h0000_8004, 1'b0, 4'h0, 32'h0);
    tick();
    tick();
    check("rst_ready", bif.req_ready_o, 4'b0000);
    check("rst_bank_req", bif.bank_req_o, 4'b0000);
    check("rst_rsp_valid", bif.rsp_valid_o, 4'b0000);
    check("rst_rsp_err", bif.rsp_err_o, 4'b0000);
    check("rst_rsp_rdata", bif.rsp_rdata_o, 128'h0);
    clear_all();
    reset = 1'b0;
    tick();

    // Single read: bank 0, word 1.
    set_req(0, 1'b1, 32'h0000_8004, 1'b0, 4'h0, 32'h0);
    #1;
    check("t1_ready", bif.req_ready_o, 4'b0001);
    check("t1_bank_req", bif.bank_req_o, 4'b0001);
    check("t1_bank_addr", bif.bank_addr_o[12:0], 13'd1);
    tick();
    clear_all();
    check("t1_rsp_valid", bif.rsp_valid_o, 4'b0001);
    check("t1_rsp_rdata", bif.rsp_rdata_o[31:0], 32'hA000_0001);
    check("t1_rsp_err", bif.rsp_err_o, 4'b0000);

    // Four-way contention on 0x1_0000 (offset 0x8000 -> bank 1, word 0).
    for (int r = 0; r < 4; r++) set_req(r, 1'b1, 32'h0001_0000, 1'b0, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      onehot = 4'b0001 << i;
      #1;
      check("t2_ready", bif.req_ready_o, onehot);
      check("t2_bank_req", bif.bank_req_o, 4'b0010);
      tick();
      bif.req_valid_i[i] = 1'b0;
      check("t2_rsp_valid", bif.rsp_valid_o, onehot);
      check("t2_rsp_rdata", bif.rsp_rdata_o[i*32 +: 32], 32'hA001_0000);
    end
    // Pointer wrapped to 0: R1 must beat R3.
    set_req(1, 1'b1, 32'h0001_0004, 1'b0, 4'h0, 32'h0);
    set_req(3, 1'b1, 32'h0001_0004, 1'b0, 4'h0, 32'h0);
    #1;
    check("t2_rr_wrap", bif.req_ready_o, 4'b0010);
    tick();
    bif.req_valid_i[1] = 1'b0;
    #1;
    check("t2_rr_next", bif.req_ready_o, 4'b1000);
    tick();
    clear_all();

    // One request per bank: all accepted together.
    set_req(0, 1'b1, 32'h0000_8000, 1'b0, 4'h0, 32'h0);
    set_req(1, 1'b1, 32'h0001_0000, 1'b0, 4'h0, 32'h0);
    set_req(2, 1'b1, 32'h0001_8000, 1'b0, 4'h0, 32'h0);
    set_req(3, 1'b1, 32'h0002_0000, 1'b0, 4'h0, 32'h0);
    #1;
    check("t3_ready", bif.req_ready_o, 4'b1111);
    check("t3_bank_req", bif.bank_req_o, 4'b1111);
    tick();
    clear_all();
    check("t3_rsp_valid", bif.rsp_valid_o, 4'b1111);
    check("t3_rsp_rdata", bif.rsp_rdata_o, {32'hA003_0000, 32'hA002_0000, 32'hA001_0000,
                                            32'hA000_0000});

    // Partial write to the last word, then read it back on the next cycle.
    set_req(1, 1'b1, 32'h0002_7FFC, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    #1;
    check("t4_ready", bif.req_ready_o, 4'b0010);
    check("t4_bank_we", bif.bank_we_o, 4'b1000);
    check("t4_bank_addr", bif.bank_addr_o[39 +: 13], 13'h1FFF);
    check("t4_bank_be", bif.bank_be_o[12 +: 4], 4'b0011);
    check("t4_bank_wdata", bif.bank_wdata_o[96 +: 32], 32'hDEAD_BEEF);
    tick();
    set_req(1, 1'b1, 32'h0002_7FFC, 1'b0, 4'h0, 32'h0);
    #1;
    check("t4_wr_rsp_valid", bif.rsp_valid_o, 4'b0010);
    check("t4_wr_rsp_rdata", bif.rsp_rdata_o[63:32], 32'h0);
    check("t4_rd_ready", bif.req_ready_o, 4'b0010);
    tick();
    clear_all();
    check("t4_rd_rsp_valid", bif.rsp_valid_o, 4'b0010);
    check("t4_rd_rsp_rdata", bif.rsp_rdata_o[63:32], 32'hA003_BEEF);

    // Decode errors: below range, above range, misaligned.
    for (int i = 0; i < 3; i++) begin
      set_req(2, 1'b1, err_addr[i], 1'b0, 4'h0, 32'h0);
      #1;
      check("t5_ready", bif.req_ready_o, 4'b0100);
      check("t5_bank_req", bif.bank_req_o, 4'b0000);
      tick();
      check("t5_rsp_valid", bif.rsp_valid_o, 4'b0100);
      check("t5_rsp_err", bif.rsp_err_o, 4'b0100);
      check("t5_rsp_rdata", bif.rsp_rdata_o[95:64], 32'h0);
    end
    clear_all();
    tick();

    // Reset right after a grant: response dropped, pointers back to 0.
    // Bank 1 pointer is 2 here, so R0 wins the first round.
    set_req(0, 1'b1, 32'h0001_0000, 1'b0, 4'h0, 32'h0);
    set_req(1, 1'b1, 32'h0001_0000, 1'b0, 4'h0, 32'h0);
    #1;
    check("t6_pre_ready", bif.req_ready_o, 4'b0001);
    tick();
    reset = 1'b1;
    #1;
    check("t6_rst_rsp_valid", bif.rsp_valid_o, 4'b0000);
    check("t6_rst_ready", bif.req_ready_o, 4'b0000);
    check("t6_rst_bank_req", bif.bank_req_o, 4'b0000);
    tick();
    reset = 1'b0;
    #1;
    check("t6_post_rsp_valid", bif.rsp_valid_o, 4'b0000);
    check("t6_post_ready", bif.req_ready_o, 4'b0001);
    tick();
    clear_all();
    check("t6_post_rsp", bif.rsp_valid_o, 4'b0001);
    tick();

`ifdef DATA_RAM_ARB_PERF_CNT_EN
    // Conflict counter: R0 and R1 on bank 1 for three cycles.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t7_perf_reset", perf, 128'h0);
    set_req(0, 1'b1, 32'h0001_0008, 1'b0, 4'h0, 32'h0);
    set_req(1, 1'b1, 32'h0001_0008, 1'b0, 4'h0, 32'h0);
    tick();
    tick();
    tick();
    clear_all();
    tick();
    check("t7_perf_count", perf, {32'd0, 32'd0, 32'd3, 32'd0});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
